instruction_fetch_unit: RTL and testbench

//  IF-stage initiator for the instruction memory: owns the PC and drives the memory's byte address.

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// IF-stage fetch unit. Owns the PC, drives the instruction memory byte address,
// and captures the returned word into the IF/ID pipeline register. Handles
// stall, flush, branch/jump redirect and a sticky halt.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-low reset
//   Stall, Flush        hold PC and IF/ID / squash the incoming instruction
//   Redirect, RedirectTarget  load a new PC (taken branch/jump)
//   Halt                stop fetching until reset
//   ImemInstruction     word read combinationally at ImemAddress
//   ImemAddress, PC     current fetch byte address
//   IfIdInstruction, IfIdPCPlus4, IfIdValid  IF/ID pipeline register
//   FetchCount          valid instructions loaded into IF/ID (wraps)
//   Halted              unit is in the HALTED state
//   MisalignErr         one-cycle pulse on a redirect with target[1:0] != 0
//   PcOutOfRange        combinational: PC beyond the instruction memory
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] ImemAddress,
  output logic [31:0] PC,
  output logic [31:0] IfIdInstruction,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid,
  output logic [31:0] FetchCount,
  output logic        Halted,
  output logic        MisalignErr,
  output logic        PcOutOfRange
);

  localparam int unsigned LP_W         = 32;
  localparam logic [LP_W-1:0] LP_IMEM_BYTES = LP_W'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          r_state;
  logic [LP_W-1:0] r_pc;
  logic [LP_W-1:0] r_ifid_instr;
  logic [LP_W-1:0] r_ifid_pcp4;
  logic            r_ifid_valid;
  logic [LP_W-1:0] r_fetch_count;
  logic            r_misalign;

  state_t          w_state_nx;
  logic [LP_W-1:0] w_pc_nx;
  logic [LP_W-1:0] w_ifid_instr_nx;
  logic [LP_W-1:0] w_ifid_pcp4_nx;
  logic            w_ifid_valid_nx;
  logic [LP_W-1:0] w_fetch_count_nx;
  logic            w_misalign_nx;
  logic [LP_W-1:0] w_pc_plus4;

  // State and pipeline registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_ifid_instr  <= '0;
      r_ifid_pcp4   <= '0;
      r_ifid_valid  <= 1'b0;
      r_fetch_count <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_pc          <= w_pc_nx;
      r_ifid_instr  <= w_ifid_instr_nx;
      r_ifid_pcp4   <= w_ifid_pcp4_nx;
      r_ifid_valid  <= w_ifid_valid_nx;
      r_fetch_count <= w_fetch_count_nx;
      r_misalign    <= w_misalign_nx;
    end
  end

  // Next-state and register update; rules in RUN are prioritised top-down
  always_comb begin
    w_state_nx       = r_state;
    w_pc_nx          = r_pc;
    w_ifid_instr_nx  = r_ifid_instr;
    w_ifid_pcp4_nx   = r_ifid_pcp4;
    w_ifid_valid_nx  = r_ifid_valid;
    w_fetch_count_nx = r_fetch_count;
    w_misalign_nx    = 1'b0;
    w_pc_plus4       = r_pc + LP_W'(4);

    case (r_state)
      S_BOOT: begin
        w_state_nx      = S_RUN;
        w_ifid_valid_nx = 1'b0;
      end
      S_RUN: begin
        if (Halt) begin
          w_state_nx      = S_HALTED;
          w_ifid_valid_nx = 1'b0;
        end else if (Redirect) begin
          // Wrong-path instruction is squashed; target is forced word-aligned
          w_pc_nx         = {RedirectTarget[LP_W-1:2], 2'b00};
          w_ifid_valid_nx = 1'b0;
          w_misalign_nx   = |RedirectTarget[1:0];
        end else if (Stall) begin
          if (Flush) begin
            w_ifid_valid_nx = 1'b0;
          end
        end else if (Flush) begin
          w_pc_nx         = w_pc_plus4;
          w_ifid_valid_nx = 1'b0;
          w_ifid_instr_nx = '0;
        end else begin
          w_pc_nx          = w_pc_plus4;
          w_ifid_instr_nx  = ImemInstruction;
          w_ifid_pcp4_nx   = w_pc_plus4;
          w_ifid_valid_nx  = 1'b1;
          w_fetch_count_nx = r_fetch_count + LP_W'(1);
        end
      end
      S_HALTED: begin
        w_ifid_valid_nx = 1'b0;
      end
      default: begin
        w_state_nx      = S_BOOT;
        w_ifid_valid_nx = 1'b0;
      end
    endcase
  end

  assign ImemAddress     = r_pc;
  assign PC              = r_pc;
  assign IfIdInstruction = r_ifid_instr;
  assign IfIdPCPlus4     = r_ifid_pcp4;
  assign IfIdValid       = r_ifid_valid;
  assign FetchCount      = r_fetch_count;
  assign Halted          = (r_state == S_HALTED);
  assign MisalignErr     = r_misalign;
  assign PcOutOfRange    = (r_pc >= LP_IMEM_BYTES);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios followed by random
// stall/flush/redirect/halt traffic, checked against a behavioural model.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall, Flush, Redirect, Halt;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemInstruction;
  logic [31:0] ImemAddress, PC, IfIdInstruction, IfIdPCPlus4, FetchCount;
  logic        IfIdValid, Halted, MisalignErr, PcOutOfRange;

  logic [31:0] mem [128];

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
  logic        m_valid, m_halted, m_booting, m_mis;

  always #5 Clk = ~Clk;

  // Combinational memory, aliasing on address bits [8:2]
  assign ImemInstruction = mem[ImemAddress[8:2]];

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .Halt(Halt),
    .ImemInstruction(ImemInstruction), .ImemAddress(ImemAddress), .PC(PC),
    .IfIdInstruction(IfIdInstruction), .IfIdPCPlus4(IfIdPCPlus4),
    .IfIdValid(IfIdValid), .FetchCount(FetchCount), .Halted(Halted),
    .MisalignErr(MisalignErr), .PcOutOfRange(PcOutOfRange)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc",        PC, m_pc);
    check("imem_addr", ImemAddress, m_pc);
    check("ifid_instr", IfIdInstruction, m_instr);
    check("ifid_pcp4", IfIdPCPlus4, m_pcp4);
    check("ifid_valid", 32'(IfIdValid), 32'(m_valid));
    check("fetch_cnt", FetchCount, m_cnt);
    check("halted",    32'(Halted), 32'(m_halted));
    check("misalign",  32'(MisalignErr), 32'(m_mis));
    check("pc_oor",    32'(PcOutOfRange), 32'(m_pc >= 32'd512));
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_booting = 1'b1; m_mis = 1'b0;
  endtask

  // Called at a negedge: drive inputs, predict, check after the posedge, return at next negedge
  task automatic cycle(input logic st, input logic fl, input logic rd,
                       input logic [31:0] tg, input logic hl);
    logic [31:0] fetched;
    Stall = st; Flush = fl; Redirect = rd; RedirectTarget = tg; Halt = hl;
    fetched = mem[m_pc[8:2]];
    m_mis = 1'b0;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (hl) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (rd) begin
      m_pc    = tg & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_mis   = (tg[1:0] != 2'b00);
    end else if (st) begin
      if (fl) m_valid = 1'b0;
    end else if (fl) begin
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b0;
      m_instr = 32'h0;
    end else begin
      m_instr = fetched;
      m_pcp4  = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    @(posedge Clk);
    #1;
    check_all();
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Reset asserted part-way through a cycle, checked before any clock edge
  task automatic mid_cycle_reset();
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    int halt_wait;
    logic [31:0] tg;
    mem[0] = 32'h2008_0064; mem[1] = 32'h2009_0006;
    mem[2] = 32'h200A_000A; mem[3] = 32'h0109_5820;
    for (int i = 4; i < 128; i++) mem[i] = $urandom;
    Stall = 0; Flush = 0; Redirect = 0; Halt = 0; RedirectTarget = 32'h0;

    // Power-on reset for 2 cycles
    Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b1;

    // BOOT, then three sequential fetches
    idle(4);
    check("boot_pc_c", PC, 32'hC);
    check("boot_cnt_3", FetchCount, 32'd3);

    // Stall two cycles, stall+flush, then resume
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1);
    // Plain flush
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1);

    // Redirect overrides stall and flush
    cycle(1'b1, 1'b1, 1'b1, 32'h30, 1'b0);
    check("redir_pc_30", PC, 32'h30);
    idle(1);
    check("redir_mem12", IfIdInstruction, mem[12]);

    // Misaligned redirect: one-cycle pulse
    cycle(1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
    check("mis_pc_40", PC, 32'h40);
    check("mis_pulse", 32'(MisalignErr), 32'd1);
    idle(1);
    check("mis_clear", 32'(MisalignErr), 32'd0);

    // Out-of-range jump: memory aliases to word 0
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    check("oor_flag", 32'(PcOutOfRange), 32'd1);
    idle(1);
    check("oor_alias", IfIdInstruction, mem[0]);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    idle(1);
    check("wrap_pc0", PC, 32'h0);
    check("wrap_pcp4", IfIdPCPlus4, 32'h0);

    // Halt at PC 0x10, frozen for 10 cycles; halt has priority over redirect
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    check("halt_pc", PC, 32'h10);

    mid_cycle_reset();
    idle(3);

    // Random traffic
    halt_wait = 0;
    for (int n = 0; n < 1500; n++) begin
      if (m_halted && !m_booting) begin
        halt_wait++;
        if (halt_wait > 4) begin
          mid_cycle_reset();
          halt_wait = 0;
          continue;
        end
      end
      case ($urandom_range(0, 3))
        0: tg = $urandom_range(0, 127) * 4;
        1: tg = $urandom_range(0, 511);
        2: tg = $urandom;
        default: tg = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      endcase
      cycle(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10), tg, ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
